// File: rtl/mips_mem_interface_pkg.sv
// Shared definitions for the multicycle MIPS memory stage and the controller:
// FSM and destination encodings, opcode constants, and the alignment helper.
package mips_mem_interface_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic {
    DEST_IR  = 1'b0,
    DEST_MDR = 1'b1
  } mem_dest_t;

  // Primary opcodes, shared with the multicycle controller decode.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic is_word_aligned(input logic [1:0] byte_offset);
    return byte_offset == 2'b00;
  endfunction

endpackage

// File: rtl/mips_access_timer.sv
// Cycle counter for an in-flight bus access; tc flags the last permitted
// WAIT cycle (count == TIMEOUT-1). Saturates there rather than wrapping.
module mips_access_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mips_mem_interface.sv
// Memory access stage: turns controller IorD/MemWrite/IRWrite into exactly one
// handshaked bus transaction per request window and loads IR or MDR on reads.
module mips_mem_interface
  import mips_mem_interface_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IorD,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       write_data,
  output logic [31:0]       instr,
  output logic [31:0]       mem_data,
  output logic              mem_busy,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  mem_state_t  state;
  mem_dest_t   dest;
  logic        served;
  logic        req;
  logic [31:0] baddr;
  logic        aligned;
  logic        start;
  logic        launch;
  logic        timer_tc;
  logic        ir_load;
  logic        mdr_load;
  logic        unused_baddr_hi;

  assign req     = IorD | MemWrite | IRWrite;
  assign baddr   = IorD ? alu_out : pc;
  assign aligned = is_word_aligned(baddr[1:0]);
  assign start   = (state == MEM_IDLE) && req && !served;
  assign launch  = start && aligned;

  // Byte-address bits above the bus word address are not decoded.
  assign unused_baddr_hi = ^baddr[31:ADDR_W+2];

  assign mem_busy = (state == MEM_WAIT) || launch;

  mips_access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (launch),
    .enable (state == MEM_WAIT),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MEM_IDLE;
      dest      <= DEST_IR;
      served    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // A dropped request re-arms the stage; completion below overrides this.
      if (!req) begin
        served <= 1'b0;
      end
      case (state)
        MEM_IDLE: begin
          if (start) begin
            if (!aligned) begin
              mem_err <= 1'b1;
              served  <= 1'b1;
            end else begin
              mem_addr  <= baddr[ADDR_W+1:2];
              mem_wdata <= write_data;
              mem_we    <= MemWrite;
              mem_req   <= 1'b1;
              dest      <= (IRWrite && !IorD) ? DEST_IR : DEST_MDR;
              state     <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          // Ack is checked first so an ack on the final cycle is not an error.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            served  <= 1'b1;
            state   <= MEM_IDLE;
          end else if (timer_tc) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
            served  <= 1'b1;
            state   <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned,
    // which would otherwise infer a latch.
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    if (state == MEM_WAIT && mem_ack && !mem_we) begin
      ir_load  = (dest == DEST_IR);
      mdr_load = (dest == DEST_MDR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= '0;
      mem_data <= '0;
    end else begin
      if (ir_load) begin
        instr <= mem_rdata;
      end
      if (mdr_load) begin
        mem_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_interface.sv
// Directed bench for mips_mem_interface: fetch, load, store, misalignment,
// timeout, and reset during an access, with hand-computed expectations.
module tb_mips_mem_interface;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              IorD;
  logic              MemWrite;
  logic              IRWrite;
  logic [31:0]       pc;
  logic [31:0]       alu_out;
  logic [31:0]       write_data;
  logic [31:0]       instr;
  logic [31:0]       mem_data;
  logic              mem_busy;
  logic              mem_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  int n_cmp = 0;
  int n_bad = 0;
  int launches = 0;
  logic prev_req = 1'b0;

  mips_mem_interface #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .pc         (pc),
    .alu_out    (alu_out),
    .write_data (write_data),
    .instr      (instr),
    .mem_data   (mem_data),
    .mem_busy   (mem_busy),
    .mem_err    (mem_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  // Counts bus transactions as rising edges of mem_req.
  always @(posedge clk) begin
    if (mem_req && !prev_req) launches++;
    prev_req = mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    pc = '0; alu_out = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    check("rst_req",   32'(mem_req),   32'd0);
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_err",   32'(mem_err),   32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", mem_wdata,      32'd0);
    check("rst_instr", instr,          32'd0);
    check("rst_mdr",   mem_data,       32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(mem_busy),  32'd0);

    // 1: instruction fetch, ack two cycles after launch
    pc = 32'h10; IRWrite = 1'b1;
    #1 check("f_busy_pre", 32'(mem_busy), 32'd1);
    tick();
    check("f_req",  32'(mem_req),  32'd1);
    check("f_addr", 32'(mem_addr), 32'h04);
    check("f_we",   32'(mem_we),   32'd0);
    tick();
    check("f_req_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h8C220004;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("f_instr",     instr,            32'h8C220004);
    check("f_req_done",  32'(mem_req),     32'd0);
    check("f_busy_post", 32'(mem_busy),    32'd0);
    tick();
    check("f_no_relaunch", 32'(launches), 32'd1);
    IRWrite = 1'b0;
    tick();

    // 2: load word, request held past completion
    IorD = 1'b1; alu_out = 32'h20;
    tick();
    check("lw_addr", 32'(mem_addr), 32'h08);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("lw_mdr",   mem_data, 32'hDEADBEEF);
    check("lw_instr", instr,    32'h8C220004);
    tick();
    check("lw_req_idle", 32'(mem_req),  32'd0);
    check("lw_single",   32'(launches), 32'd2);
    IorD = 1'b0;
    tick();

    // 3: store word
    IorD = 1'b1; MemWrite = 1'b1; alu_out = 32'h44; write_data = 32'h12345678;
    tick();
    check("sw_req",   32'(mem_req),  32'd1);
    check("sw_we",    32'(mem_we),   32'd1);
    check("sw_addr",  32'(mem_addr), 32'h11);
    check("sw_wdata", mem_wdata,     32'h12345678);
    write_data = 32'hA5A5A5A5;
    tick();
    check("sw_wdata_hold", mem_wdata, 32'h12345678);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("sw_req_done", 32'(mem_req), 32'd0);
    check("sw_mdr",      mem_data,     32'hDEADBEEF);
    check("sw_instr",    instr,        32'h8C220004);
    IorD = 1'b0; MemWrite = 1'b0;
    tick();

    // 4: misaligned data access
    IorD = 1'b1; alu_out = 32'h22;
    #1 check("mis_busy", 32'(mem_busy), 32'd0);
    tick();
    check("mis_err", 32'(mem_err), 32'd1);
    check("mis_req", 32'(mem_req), 32'd0);
    tick();
    IorD = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("mis_idle_ack_mdr", mem_data, 32'hDEADBEEF);
    tick();
    check("mis_err_sticky", 32'(mem_err),  32'd1);
    check("mis_no_launch",  32'(launches), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mis_err_rst", 32'(mem_err), 32'd0);
    tick();

    // 5a: timeout, memory never acks
    pc = 32'h100; IRWrite = 1'b1;
    tick();
    check("to_addr", 32'(mem_addr), 32'h40);
    tick(); check("to_req_c2", 32'(mem_req), 32'd1);
    tick(); check("to_req_c3", 32'(mem_req), 32'd1);
    tick(); check("to_req_c4", 32'(mem_req), 32'd1);
    check("to_err_pre", 32'(mem_err), 32'd0);
    tick();
    check("to_req_off", 32'(mem_req),  32'd0);
    check("to_err",     32'(mem_err),  32'd1);
    check("to_busy",    32'(mem_busy), 32'd0);
    check("to_instr",   instr,         32'd0);
    IRWrite = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 5b: ack on the final permitted cycle wins over timeout
    pc = 32'h14; IRWrite = 1'b1;
    tick(); tick(); tick(); tick();
    check("ta_req_c4", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("ta_err",   32'(mem_err), 32'd0);
    check("ta_instr", instr,        32'hCAFEF00D);
    check("ta_req",   32'(mem_req), 32'd0);
    IRWrite = 1'b0;
    tick();

    // 6: reset while an access is in flight, then a clean fetch
    IorD = 1'b1; MemWrite = 1'b1; alu_out = 32'h30; write_data = 32'h55AA55AA;
    tick();
    check("rw_req_pre", 32'(mem_req), 32'd1);
    IorD = 1'b0; MemWrite = 1'b0;
    rst = 1'b1;
    tick();
    check("rw_req",   32'(mem_req),   32'd0);
    check("rw_we",    32'(mem_we),    32'd0);
    check("rw_addr",  32'(mem_addr),  32'd0);
    check("rw_wdata", mem_wdata,      32'd0);
    check("rw_instr", instr,          32'd0);
    check("rw_busy",  32'(mem_busy),  32'd0);
    rst = 1'b0;
    tick();
    pc = 32'h08; IRWrite = 1'b1;
    tick();
    check("rf_addr", 32'(mem_addr), 32'h02);
    mem_ack = 1'b1; mem_rdata = 32'h24080001;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("rf_instr", instr,          32'h24080001);
    check("rf_err",   32'(mem_err),   32'd0);
    check("rf_count", 32'(launches),  32'd7);
    IRWrite = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
